aes_hpc2_word_adapter: RTL and testbench
========================================

// Module: aes_hpc2_word_adapter
// PURPOSE
//   Word-serial front/back end for the masked 32-bit HPC2 AES top.
//   Deserialises shared key and plaintext words from a narrow valid/ready stream into
//   the two 128*d-bit share buses, and presents them together on the AES input handshake.
//   Captures the 128*d-bit shared ciphertext and replays it as a word stream.
//   Never combines shares; it only moves share words.
// PARAMETERS
//   d       2   masking order + 1 (number of shares per bit)
//   WORD_W  32  stream word width; 128*d must be a multiple of WORD_W
// PORTS
//   clk                         in   1         clock
//   rst                         in   1         synchronous reset, active-high
//   s_word_valid                in   1         input word valid
//   s_word_ready                out  1         input word ready
//   s_word_data                 in   WORD_W    input share word (key words first, then plaintext)
//   core_in_valid               out  1         to AES in_valid
//   core_in_ready               in   1         from AES in_ready
//   core_in_shares_key          out  128*d     to AES in_shares_key
//   core_in_shares_plaintext    out  128*d     to AES in_shares_plaintext
//   core_out_shares_ciphertext  in   128*d     from AES out_shares_ciphertext
//   core_out_valid              in   1         from AES out_valid
//   core_out_ready              out  1         to AES out_ready
//   m_word_valid                out  1         output word valid
//   m_word_ready                in   1         output word ready
//   m_word_data                 out  WORD_W    output ciphertext share word
//   m_word_last                 out  1         high on the final word of a ciphertext
// BEHAVIOUR
//   NW = 128*d/WORD_W words per bus. Word i maps to bus bits [WORD_W*i +: WORD_W]; word 0 comes first.
//   Input FSM states: LOAD_KEY, LOAD_PT, PRESENT.
//   - LOAD_KEY / LOAD_PT:
//     - s_word_ready=1 and core_in_valid=0.
//     - Each s_word handshake writes word cnt of the key/pt buffer and then increments cnt.
//     - At cnt==NW-1, the handshake clears cnt and advances (LOAD_KEY->LOAD_PT->PRESENT).
//   - PRESENT:
//     - s_word_ready=0 and core_in_valid=1.
//     - The key and pt buffers stay stable.
//     - On core_in_valid&core_in_ready the FSM goes to LOAD_KEY.
//   - core_in_valid rises in the cycle after the last plaintext word is accepted. No combinational s->core path.
//   - Every block reloads both key and plaintext; there is no key reuse.
//   Output FSM states: EMPTY, SEND.
//   - core_out_ready = (EMPTY) | (SEND & m_word_valid & m_word_ready & m_word_last).
//     This gives back-to-back ciphertexts with no bubble.
//   - A core_out handshake captures the full bus into the ct buffer, sets ocnt=0 and enters SEND.
//     m_word_valid rises in the next cycle.
//   - SEND:
//     - m_word_valid=1 and m_word_data=ct[WORD_W*ocnt +: WORD_W].
//     - m_word_last=(ocnt==NW-1).
//     - A handshake increments ocnt.
//     - On the last word, go to EMPTY, unless a simultaneous capture occurs; then stay in SEND with ocnt=0.
//   - Under backpressure, m_word_data and m_word_last hold stable while valid&!ready.
//   - The input and output paths are independent and may run concurrently.
//   Reset:
//     - State goes to LOAD_KEY/EMPTY and all counters clear.
//     - Outputs after reset: s_word_ready=1, core_in_valid=0, core_out_ready=1, m_word_valid=0, m_word_last=0.
//     - All buffers are zeroed, so the share buses read 0.
//     - Reset mid-load discards partial words. Reset mid-SEND drops the remaining words.
// STRUCTURE
//   Shared package holds localparam NW, the counter width $clog2(NW), and the state encodings.
//   One sub-module, shbuf_word_ser:
//   - a generic NW x WORD_W parallel-load/word-indexed read buffer with counter, used for the output path;
//   - the input path uses indexed word writes into the two buffers.
// TESTING (d=2, WORD_W=32, NW=8)
//   1. Reset
//      -> s_word_ready=1, core_in_valid=0, core_out_ready=1, m_word_valid=0, buses=0.
//   2. Stream 16 words: key 0x1000+i, then pt 0x2000+i
//      -> key[32*i+:32]=0x1000+i and pt[32*i+:32]=0x2000+i;
//      -> core_in_valid=1 one cycle after word 16, with s_word_ready=0;
//      -> with core_in_ready held 0 for 5 cycles, both stay unchanged;
//      -> after the handshake, s_word_ready=1.
//   3. core_out_valid with ct word i=0xC000+i, m_word_ready=1
//      -> 0xC000..0xC007 on 8 consecutive cycles, last only on 0xC007;
//      -> core_out_ready=0 until the last word.
//   4. m_word_ready alternating 1/0
//      -> no word lost or duplicated; data stable while stalled.
//   5. Second ciphertext valid during the last-word handshake
//      -> captured that cycle; its word 0 appears the next cycle.
//   6. rst after 5 key words, then 16 fresh words
//      -> buses hold only the fresh words; core_in_valid after word 16.

Source files
------------

// File: rtl/aes_hpc2_word_adapter_pkg.sv
// Shared sizing helpers and state encodings for the HPC2 AES word-serial adapter.
// The default bus geometry matches the d=2, 32-bit word configuration.
package aes_hpc2_word_adapter_pkg;

  function automatic int words_per_bus(input int shares, input int word_w);
    return (128 * shares) / word_w;
  endfunction

  // A counter needs at least one bit even when a bus is a single word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int D_DEFAULT      = 2;
  localparam int WORD_W_DEFAULT = 32;
  localparam int NW             = words_per_bus(D_DEFAULT, WORD_W_DEFAULT);
  localparam int CNT_W          = cnt_width(NW);

  typedef enum logic [1:0] {
    IN_LOAD_KEY = 2'd0,
    IN_LOAD_PT  = 2'd1,
    IN_PRESENT  = 2'd2
  } in_state_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_SEND  = 1'b1
  } out_state_t;

endpackage

// File: rtl/aes_hpc2_word_adapter_shbuf_word_ser.sv
// Parallel-load share buffer read out one word at a time by an internal index.
// Load has priority over advance and restarts the index at word 0.
module shbuf_word_ser
  import aes_hpc2_word_adapter_pkg::*;
#(
  parameter int N_WORDS = NW,
  parameter int WORD_W  = WORD_W_DEFAULT,
  parameter int IDX_W   = cnt_width(N_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [N_WORDS*WORD_W-1:0]   load_data,
  input  logic                        advance,
  output logic [WORD_W-1:0]           word,
  output logic [IDX_W-1:0]            idx,
  output logic                        at_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  logic [IDX_W-1:0]  idx_reg;
  logic [WORD_W-1:0] words [N_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (load) begin
          word_reg <= load_data[WORD_W*gi +: WORD_W];
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (load) begin
      idx_reg <= '0;
    end else if (advance) begin
      idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
  end

  assign idx     = idx_reg;
  assign word    = words[idx_reg];
  assign at_last = (idx_reg == LAST_IDX);

endmodule

// File: rtl/aes_hpc2_word_adapter.sv
// Word-serial front/back end for the masked HPC2 AES core: gathers key and plaintext share
// words into full buses, and replays the captured ciphertext bus as a word stream.
module aes_hpc2_word_adapter
  import aes_hpc2_word_adapter_pkg::*;
#(
  parameter int d      = D_DEFAULT,
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_word_valid,
  output logic                  s_word_ready,
  input  logic [WORD_W-1:0]     s_word_data,
  output logic                  core_in_valid,
  input  logic                  core_in_ready,
  output logic [128*d-1:0]      core_in_shares_key,
  output logic [128*d-1:0]      core_in_shares_plaintext,
  input  logic [128*d-1:0]      core_out_shares_ciphertext,
  input  logic                  core_out_valid,
  output logic                  core_out_ready,
  output logic                  m_word_valid,
  input  logic                  m_word_ready,
  output logic [WORD_W-1:0]     m_word_data,
  output logic                  m_word_last
);

  localparam int N_WORDS = words_per_bus(d, WORD_W);
  localparam int IDX_W   = cnt_width(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  // ---------------- input path ----------------
  in_state_t        in_state_reg, in_state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic             s_hs;
  logic             key_we;
  logic             pt_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_reg <= IN_LOAD_KEY;
      cnt_reg      <= '0;
    end else begin
      in_state_reg <= in_state_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    in_state_next = in_state_reg;
    cnt_next      = cnt_reg;
    s_word_ready  = 1'b0;
    core_in_valid = 1'b0;
    key_we        = 1'b0;
    pt_we         = 1'b0;
    s_hs          = 1'b0;

    case (in_state_reg)
      IN_LOAD_KEY, IN_LOAD_PT: begin
        s_word_ready = 1'b1;
        s_hs         = s_word_valid;
        key_we       = s_hs && (in_state_reg == IN_LOAD_KEY);
        pt_we        = s_hs && (in_state_reg == IN_LOAD_PT);
        if (s_hs) begin
          if (cnt_reg == LAST_IDX) begin
            cnt_next      = '0;
            in_state_next = (in_state_reg == IN_LOAD_KEY) ? IN_LOAD_PT : IN_PRESENT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      IN_PRESENT: begin
        core_in_valid = 1'b1;
        if (core_in_ready) begin
          in_state_next = IN_LOAD_KEY;
        end
      end
      default: begin
        in_state_next = IN_LOAD_KEY;
        cnt_next      = '0;
      end
    endcase
  end

  // Each word slot owns its register, so the buses only change on their own write strobe.
  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_in_word
      logic [WORD_W-1:0] key_word_reg;
      logic [WORD_W-1:0] pt_word_reg;
      logic              slot_sel;

      assign slot_sel = (cnt_reg == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          key_word_reg <= '0;
          pt_word_reg  <= '0;
        end else begin
          if (key_we && slot_sel) begin
            key_word_reg <= s_word_data;
          end
          if (pt_we && slot_sel) begin
            pt_word_reg <= s_word_data;
          end
        end
      end

      assign core_in_shares_key[WORD_W*gi +: WORD_W]       = key_word_reg;
      assign core_in_shares_plaintext[WORD_W*gi +: WORD_W] = pt_word_reg;
    end
  endgenerate

  // ---------------- output path ----------------
  out_state_t       out_state_reg, out_state_next;
  logic             capture;
  logic             m_hs;
  logic             ct_at_last;
  logic [IDX_W-1:0] ocnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_reg <= OUT_EMPTY;
    end else begin
      out_state_reg <= out_state_next;
    end
  end

  always_comb begin
    out_state_next = out_state_reg;
    m_word_valid   = (out_state_reg == OUT_SEND);
    m_word_last    = m_word_valid && ct_at_last;
    m_hs           = m_word_valid && m_word_ready;
    // Accepting the next ciphertext on the final word handshake avoids a bubble.
    core_out_ready = (out_state_reg == OUT_EMPTY) || (m_hs && m_word_last);
    capture        = core_out_valid && core_out_ready;

    if (capture) begin
      out_state_next = OUT_SEND;
    end else if (m_hs && m_word_last) begin
      out_state_next = OUT_EMPTY;
    end
  end

  shbuf_word_ser #(
    .N_WORDS (N_WORDS),
    .WORD_W  (WORD_W),
    .IDX_W   (IDX_W)
  ) u_ct_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (core_out_shares_ciphertext),
    .advance   (m_hs),
    .word      (m_word_data),
    .idx       (ocnt),
    .at_last   (ct_at_last)
  );

  logic unused_ocnt;
  assign unused_ocnt = ^ocnt;

endmodule

// File: tb/tb_aes_hpc2_word_adapter.sv
// Directed bench for the HPC2 AES word adapter (d=2, 32-bit words, 8 words per bus).
// Inputs change 1ns after a rising edge; outputs are checked 1ns later.
module tb_aes_hpc2_word_adapter;

  localparam int D      = 2;
  localparam int WW     = 32;
  localparam int NWB    = 8;
  localparam int BUS_W  = 128 * D;

  logic              clk;
  logic              rst;
  logic              s_word_valid;
  logic              s_word_ready;
  logic [WW-1:0]     s_word_data;
  logic              core_in_valid;
  logic              core_in_ready;
  logic [BUS_W-1:0]  core_in_shares_key;
  logic [BUS_W-1:0]  core_in_shares_plaintext;
  logic [BUS_W-1:0]  core_out_shares_ciphertext;
  logic              core_out_valid;
  logic              core_out_ready;
  logic              m_word_valid;
  logic              m_word_ready;
  logic [WW-1:0]     m_word_data;
  logic              m_word_last;

  int n_checks = 0;
  int n_pass   = 0;

  aes_hpc2_word_adapter #(.d(D), .WORD_W(WW)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .s_word_valid               (s_word_valid),
    .s_word_ready               (s_word_ready),
    .s_word_data                (s_word_data),
    .core_in_valid              (core_in_valid),
    .core_in_ready              (core_in_ready),
    .core_in_shares_key         (core_in_shares_key),
    .core_in_shares_plaintext   (core_in_shares_plaintext),
    .core_out_shares_ciphertext (core_out_shares_ciphertext),
    .core_out_valid             (core_out_valid),
    .core_out_ready             (core_out_ready),
    .m_word_valid               (m_word_valid),
    .m_word_ready               (m_word_ready),
    .m_word_data                (m_word_data),
    .m_word_last                (m_word_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BUS_W-1:0] make_bus(input logic [WW-1:0] base);
    logic [BUS_W-1:0] v;
    for (int i = 0; i < NWB; i++) v[WW*i +: WW] = base + WW'(i);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Streams NWB key words then NWB plaintext words, checking ready on every word.
  task automatic load_block(input logic [WW-1:0] kbase, input logic [WW-1:0] pbase,
                            input string tag);
    for (int i = 0; i < 2 * NWB; i++) begin
      s_word_valid = 1'b1;
      s_word_data  = (i < NWB) ? kbase + WW'(i) : pbase + WW'(i - NWB);
      #1;
      n_checks++;
      if (s_word_ready !== 1'b1 || core_in_valid !== 1'b0)
        $display("FAIL %s_word%0d: s_word_ready=%b core_in_valid=%b, required 1 0",
                 tag, i, s_word_ready, core_in_valid);
      else n_pass++;
      tick();
    end
    s_word_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (s_word_ready !== 1'b1 || core_in_valid !== 1'b0 || core_out_ready !== 1'b1 ||
        m_word_valid !== 1'b0 || m_word_last !== 1'b0)
      $display("FAIL reset_ctrl: srdy=%b civ=%b cordy=%b mv=%b ml=%b, required 1 0 1 0 0",
               s_word_ready, core_in_valid, core_out_ready, m_word_valid, m_word_last);
    else n_pass++;
    n_checks++;
    if (core_in_shares_key !== '0 || core_in_shares_plaintext !== '0)
      $display("FAIL reset_buses: key=%h pt=%h, required 0", core_in_shares_key,
               core_in_shares_plaintext);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [BUS_W-1:0] ek;
    logic [BUS_W-1:0] ep;
    ek = make_bus(32'h1000);
    ep = make_bus(32'h2000);
    load_block(32'h1000, 32'h2000, "load");
    n_checks++;
    if (core_in_valid !== 1'b1 || s_word_ready !== 1'b0)
      $display("FAIL load_present: core_in_valid=%b s_word_ready=%b, required 1 0",
               core_in_valid, s_word_ready);
    else n_pass++;
    n_checks++;
    if (core_in_shares_key !== ek) $display("FAIL load_key: got %h, required %h",
                                            core_in_shares_key, ek);
    else n_pass++;
    n_checks++;
    if (core_in_shares_plaintext !== ep) $display("FAIL load_pt: got %h, required %h",
                                                  core_in_shares_plaintext, ep);
    else n_pass++;
    // Stall the core side and push stray words that must be ignored.
    s_word_valid = 1'b1;
    s_word_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (core_in_valid !== 1'b1 || s_word_ready !== 1'b0 ||
          core_in_shares_key !== ek || core_in_shares_plaintext !== ep)
        $display("FAIL stall_cycle%0d: civ=%b srdy=%b key=%h pt=%h, required 1 0 %h %h",
                 c, core_in_valid, s_word_ready, core_in_shares_key,
                 core_in_shares_plaintext, ek, ep);
      else n_pass++;
    end
    s_word_valid  = 1'b0;
    core_in_ready = 1'b1;
    tick();
    core_in_ready = 1'b0;
    #1;
    n_checks++;
    if (s_word_ready !== 1'b1 || core_in_valid !== 1'b0)
      $display("FAIL after_core_hs: s_word_ready=%b core_in_valid=%b, required 1 0",
               s_word_ready, core_in_valid);
    else n_pass++;
  endtask

  task automatic capture_ct(input logic [WW-1:0] base);
    core_out_valid             = 1'b1;
    core_out_shares_ciphertext = make_bus(base);
    #1;
    n_checks++;
    if (core_out_ready !== 1'b1)
      $display("FAIL capture_%h: core_out_ready=%b, required 1", base, core_out_ready);
    else n_pass++;
    tick();
    core_out_valid = 1'b0;
  endtask

  // Drains one ciphertext with m_word_ready held high; optionally offers the next one
  // alongside the final word.
  task automatic drain_ct(input logic [WW-1:0] base, input bit offer_next,
                          input logic [WW-1:0] next_base);
    m_word_ready = 1'b1;
    for (int i = 0; i < NWB; i++) begin
      if (offer_next && i == NWB - 1) begin
        core_out_valid             = 1'b1;
        core_out_shares_ciphertext = make_bus(next_base);
      end
      #1;
      n_checks++;
      if (m_word_valid !== 1'b1 || m_word_data !== base + WW'(i) ||
          m_word_last !== (i == NWB - 1) || core_out_ready !== (i == NWB - 1))
        $display("FAIL drain_%h_w%0d: v=%b data=%h last=%b cordy=%b, required 1 %h %b %b",
                 base, i, m_word_valid, m_word_data, m_word_last, core_out_ready,
                 base + WW'(i), (i == NWB - 1), (i == NWB - 1));
      else n_pass++;
      tick();
    end
    core_out_valid = 1'b0;
  endtask

  task automatic test_stream_out();
    capture_ct(32'hC000);
    drain_ct(32'hC000, 1'b0, '0);
    #1;
    n_checks++;
    if (m_word_valid !== 1'b0 || core_out_ready !== 1'b1)
      $display("FAIL stream_done: m_word_valid=%b core_out_ready=%b, required 0 1",
               m_word_valid, core_out_ready);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int k;
    k = 0;
    capture_ct(32'hD000);
    for (int c = 0; c < 40 && k < NWB; c++) begin
      m_word_ready = (c % 2 == 1);
      #1;
      n_checks++;
      if (m_word_valid !== 1'b1 || m_word_data !== 32'hD000 + WW'(k) ||
          m_word_last !== (k == NWB - 1))
        $display("FAIL bp_cycle%0d: v=%b data=%h last=%b, required 1 %h %b",
                 c, m_word_valid, m_word_data, m_word_last, 32'hD000 + WW'(k), (k == NWB - 1));
      else n_pass++;
      if (m_word_ready) k++;
      tick();
    end
    m_word_ready = 1'b0;
    #1;
    n_checks++;
    if (k != NWB || m_word_valid !== 1'b0)
      $display("FAIL bp_count: words=%0d valid=%b, required %0d 0", k, m_word_valid, NWB);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    capture_ct(32'hE000);
    drain_ct(32'hE000, 1'b1, 32'hF000);
    drain_ct(32'hF000, 1'b0, '0);
    m_word_ready = 1'b0;
    #1;
    n_checks++;
    if (m_word_valid !== 1'b0)
      $display("FAIL b2b_done: m_word_valid=%b, required 0", m_word_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    logic [BUS_W-1:0] ek;
    logic [BUS_W-1:0] ep;
    for (int i = 0; i < 5; i++) begin
      s_word_valid = 1'b1;
      s_word_data  = 32'h3000 + WW'(i);
      tick();
    end
    s_word_valid = 1'b0;
    // Also leave the output path mid-ciphertext so the reset must drop it.
    capture_ct(32'hA000);
    m_word_ready = 1'b1;
    tick();
    tick();
    m_word_ready = 1'b0;
    do_reset();
    #1;
    n_checks++;
    if (core_in_shares_key !== '0 || m_word_valid !== 1'b0 || core_out_ready !== 1'b1 ||
        s_word_ready !== 1'b1)
      $display("FAIL midreset_state: key=%h mv=%b cordy=%b srdy=%b, required 0 0 1 1",
               core_in_shares_key, m_word_valid, core_out_ready, s_word_ready);
    else n_pass++;
    ek = make_bus(32'h5000);
    ep = make_bus(32'h6000);
    load_block(32'h5000, 32'h6000, "reload");
    n_checks++;
    if (core_in_valid !== 1'b1 || core_in_shares_key !== ek || core_in_shares_plaintext !== ep)
      $display("FAIL reload_buses: civ=%b key=%h pt=%h, required 1 %h %h",
               core_in_valid, core_in_shares_key, core_in_shares_plaintext, ek, ep);
    else n_pass++;
  endtask

  initial begin
    rst                        = 1'b1;
    s_word_valid               = 1'b0;
    s_word_data                = '0;
    core_in_ready              = 1'b0;
    core_out_shares_ciphertext = '0;
    core_out_valid             = 1'b0;
    m_word_ready               = 1'b0;
    #1;
    test_reset();
    test_load();
    test_stream_out();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
